// File: rtl/cursor_ctrl_pkg.sv
// Shared types and constants for the cursor/selection controller.
package cursor_ctrl_pkg;

    localparam int COORD_W      = 10;
    localparam int ACCEL_THRESH = 8;
    localparam int ACCEL_MULT   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NAV  = 2'd1,
        ST_ANC  = 2'd2,
        ST_LOCK = 2'd3
    } state_t;

    // Move one coordinate by amt (11-bit intermediate), floor at 0, cap at vmax.
    function automatic logic [COORD_W-1:0] f_move(
        input logic [COORD_W-1:0] v,
        input logic               inc,
        input logic               dec,
        input logic [COORD_W:0]   amt,
        input logic [COORD_W:0]   vmax
    );
        logic [COORD_W:0] s;
        s = {1'b0, v};
        if (inc)
            s = s + amt;
        else if (dec)
            s = (s < amt) ? '0 : s - amt;
        if (s > vmax)
            s = vmax;
        return s[COORD_W-1:0];
    endfunction

    // Re-clamp a stored coordinate when the image shrinks.
    function automatic logic [COORD_W-1:0] f_clamp(
        input logic [COORD_W-1:0] v,
        input logic [COORD_W:0]   vmax
    );
        return ({1'b0, v} > vmax) ? vmax[COORD_W-1:0] : v;
    endfunction

endpackage

// File: rtl/cursor_key_repeat.sv
// One direction button: rising-edge step plus frame-counted auto-repeat.
// With CURSOR_SELECTION_CTRL_ACCEL_EN defined, also flags fast steps after
// ACCEL_THRESH consecutive repeats.
module cursor_key_repeat
    import cursor_ctrl_pkg::*;
#(
    parameter int REPEAT_DELAY  = 20,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic clk_vga,
    input  logic reset,
    input  logic btn,
    input  logic frame_start,
`ifdef CURSOR_SELECTION_CTRL_ACCEL_EN
    output logic fast,
`endif
    output logic step
);

    localparam int CNT_MAX = REPEAT_DELAY + REPEAT_PERIOD;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] C_DLY = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] C_MAX = CW'(CNT_MAX);

    logic          r_btn_d;
    logic          r_step;
    logic [CW-1:0] r_cnt;
    logic          w_rise;
    logic          w_rep;
    logic [CW-1:0] w_cnt_inc;

    assign w_rise    = btn & ~r_btn_d;
    assign w_cnt_inc = r_cnt + 1'b1;
    // Repeat fires when the frame count reaches the delay, then at each period.
    assign w_rep     = btn & frame_start & ((w_cnt_inc == C_DLY) | (w_cnt_inc == C_MAX));
    assign step      = r_step;

    // Edge detect, hold counter (reloads to delay at delay+period, never wraps).
    always_ff @(posedge clk_vga or posedge reset) begin
        if (reset) begin
            r_btn_d <= 1'b0;
            r_step  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_btn_d <= btn;
            r_step  <= w_rise | w_rep;
            if (!btn)
                r_cnt <= '0;
            else if (frame_start)
                r_cnt <= (w_cnt_inc == C_MAX) ? C_DLY : w_cnt_inc;
        end
    end

`ifdef CURSOR_SELECTION_CTRL_ACCEL_EN
    localparam logic [3:0] C_ACC = 4'(ACCEL_THRESH);
    logic [3:0] r_acc;
    logic       r_fast;

    assign fast = r_fast;

    // Count repeats while held; the repeat after the threshold is fast.
    always_ff @(posedge clk_vga or posedge reset) begin
        if (reset) begin
            r_acc  <= '0;
            r_fast <= 1'b0;
        end else if (!btn) begin
            r_acc  <= '0;
            r_fast <= 1'b0;
        end else if (w_rep) begin
            r_fast <= (r_acc == C_ACC);
            if (r_acc != C_ACC)
                r_acc <= r_acc + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/cursor_selection_ctrl.sv
// Cursor and selection controller for the VGA overlay. Direction buttons
// move a clamped cursor; select/cancel drive IDLE/NAVIGATE/ANCHORED/LOCKED.
// Overlay outputs are shadowed and only update on frame_start.
// Optional: CURSOR_SELECTION_CTRL_ACCEL_EN enables 4x step after long holds.
module cursor_selection_ctrl
    import cursor_ctrl_pkg::*;
#(
    parameter int STEP          = 1,
    parameter int REPEAT_DELAY  = 20,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic               clk_vga,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               ctrl_enable,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_select,
    input  logic               btn_cancel,
    input  logic [COORD_W-1:0] img_w,
    input  logic [COORD_W-1:0] img_h,
    output logic               cursor_enable,
    output logic [COORD_W-1:0] cursor_x,
    output logic [COORD_W-1:0] cursor_y,
    output logic               selection_enable,
    output logic [COORD_W-1:0] sel_x1,
    output logic [COORD_W-1:0] sel_y1,
    output logic [COORD_W-1:0] sel_x2,
    output logic [COORD_W-1:0] sel_y2,
    output logic               sel_done,
    output logic [1:0]         state_o
);

    localparam logic [COORD_W:0] C_STEP = (COORD_W+1)'(STEP);

    state_t             r_state, w_state_nx;
    logic               r_sel_d, r_can_d, r_sel_done;
    logic [COORD_W-1:0] r_cx, r_cy, r_x1, r_y1, r_x2, r_y2;
    logic [COORD_W-1:0] w_cx_nx, w_cy_nx, w_x1_nx, w_y1_nx, w_x2_nx, w_y2_nx;
    logic               r_o_cen, r_o_sen;
    logic [COORD_W-1:0] r_o_cx, r_o_cy, r_o_x1, r_o_y1, r_o_x2, r_o_y2;
    logic               w_stp_u, w_stp_d, w_stp_l, w_stp_r;
    logic               w_sel_rise, w_can_rise, w_mv_en;
    logic               w_inc_x, w_dec_x, w_inc_y, w_dec_y;
    logic [COORD_W:0]   w_xmax, w_ymax, w_amt_u, w_amt_d, w_amt_l, w_amt_r;
    logic [COORD_W:0]   w_amt_x, w_amt_y;

`ifdef CURSOR_SELECTION_CTRL_ACCEL_EN
    localparam logic [COORD_W:0] C_STEP_F = (COORD_W+1)'(STEP * ACCEL_MULT);
    logic w_fast_u, w_fast_d, w_fast_l, w_fast_r;
    assign w_amt_u = w_fast_u ? C_STEP_F : C_STEP;
    assign w_amt_d = w_fast_d ? C_STEP_F : C_STEP;
    assign w_amt_l = w_fast_l ? C_STEP_F : C_STEP;
    assign w_amt_r = w_fast_r ? C_STEP_F : C_STEP;
`else
    assign w_amt_u = C_STEP;
    assign w_amt_d = C_STEP;
    assign w_amt_l = C_STEP;
    assign w_amt_r = C_STEP;
`endif

    cursor_key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_up (
        .clk_vga(clk_vga), .reset(reset), .btn(btn_up), .frame_start(frame_start),
`ifdef CURSOR_SELECTION_CTRL_ACCEL_EN
        .fast(w_fast_u),
`endif
        .step(w_stp_u));
    cursor_key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_down (
        .clk_vga(clk_vga), .reset(reset), .btn(btn_down), .frame_start(frame_start),
`ifdef CURSOR_SELECTION_CTRL_ACCEL_EN
        .fast(w_fast_d),
`endif
        .step(w_stp_d));
    cursor_key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_left (
        .clk_vga(clk_vga), .reset(reset), .btn(btn_left), .frame_start(frame_start),
`ifdef CURSOR_SELECTION_CTRL_ACCEL_EN
        .fast(w_fast_l),
`endif
        .step(w_stp_l));
    cursor_key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_right (
        .clk_vga(clk_vga), .reset(reset), .btn(btn_right), .frame_start(frame_start),
`ifdef CURSOR_SELECTION_CTRL_ACCEL_EN
        .fast(w_fast_r),
`endif
        .step(w_stp_r));

    assign w_sel_rise = btn_select & ~r_sel_d;
    assign w_can_rise = btn_cancel & ~r_can_d;
    assign w_xmax     = (img_w == '0) ? '0 : {1'b0, img_w} - 1'b1;
    assign w_ymax     = (img_h == '0) ? '0 : {1'b0, img_h} - 1'b1;
    assign w_mv_en    = (r_state == ST_NAV) || (r_state == ST_ANC);
    // An axis moves only if the opposing direction is neither held nor stepping.
    assign w_inc_x    = w_mv_en & w_stp_r & ~(btn_left  | w_stp_l);
    assign w_dec_x    = w_mv_en & w_stp_l & ~(btn_right | w_stp_r);
    assign w_inc_y    = w_mv_en & w_stp_d & ~(btn_up    | w_stp_u);
    assign w_dec_y    = w_mv_en & w_stp_u & ~(btn_down  | w_stp_d);
    assign w_amt_x    = w_inc_x ? w_amt_r : w_amt_l;
    assign w_amt_y    = w_inc_y ? w_amt_d : w_amt_u;

    // Next state and next working cursor/corners.
    always_comb begin
        w_state_nx = r_state;
        w_cx_nx    = f_move(r_cx, w_inc_x, w_dec_x, w_amt_x, w_xmax);
        w_cy_nx    = f_move(r_cy, w_inc_y, w_dec_y, w_amt_y, w_ymax);
        w_x1_nx    = f_clamp(r_x1, w_xmax);
        w_y1_nx    = f_clamp(r_y1, w_ymax);
        w_x2_nx    = f_clamp(r_x2, w_xmax);
        w_y2_nx    = f_clamp(r_y2, w_ymax);
        case (r_state)
            ST_IDLE: begin
                w_state_nx = ST_NAV;
                w_cx_nx    = {1'b0, img_w[COORD_W-1:1]};
                w_cy_nx    = {1'b0, img_h[COORD_W-1:1]};
                {w_x1_nx, w_y1_nx, w_x2_nx, w_y2_nx} = '0;
            end
            ST_NAV: begin
                {w_x1_nx, w_y1_nx, w_x2_nx, w_y2_nx} = '0;
                if (w_sel_rise && !w_can_rise) begin
                    w_state_nx = ST_ANC;
                    w_x1_nx    = w_cx_nx;
                    w_y1_nx    = w_cy_nx;
                    w_x2_nx    = w_cx_nx;
                    w_y2_nx    = w_cy_nx;
                end
            end
            ST_ANC: begin
                w_x2_nx = w_cx_nx;
                w_y2_nx = w_cy_nx;
                if (w_can_rise) begin
                    w_state_nx = ST_NAV;
                    {w_x1_nx, w_y1_nx, w_x2_nx, w_y2_nx} = '0;
                end else if (w_sel_rise) begin
                    w_state_nx = ST_LOCK;
                end
            end
            default: begin
                if (w_can_rise) begin
                    w_state_nx = ST_NAV;
                    {w_x1_nx, w_y1_nx, w_x2_nx, w_y2_nx} = '0;
                end
            end
        endcase
        if (!ctrl_enable)
            w_state_nx = ST_IDLE;
    end

    // State, button edge history and working registers; disable zeroes all.
    always_ff @(posedge clk_vga or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_sel_d    <= 1'b0;
            r_can_d    <= 1'b0;
            r_sel_done <= 1'b0;
            {r_cx, r_cy, r_x1, r_y1, r_x2, r_y2} <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_sel_d    <= btn_select;
            r_can_d    <= btn_cancel;
            // High in the first cycle that state_o reads LOCKED.
            r_sel_done <= (r_state == ST_ANC) && (w_state_nx == ST_LOCK);
            if (!ctrl_enable)
                {r_cx, r_cy, r_x1, r_y1, r_x2, r_y2} <= '0;
            else
                {r_cx, r_cy, r_x1, r_y1, r_x2, r_y2} <=
                    {w_cx_nx, w_cy_nx, w_x1_nx, w_y1_nx, w_x2_nx, w_y2_nx};
        end
    end

    // Overlay shadow copy, refreshed only at frame start so the overlay never tears.
    always_ff @(posedge clk_vga or posedge reset) begin
        if (reset) begin
            r_o_cen <= 1'b0;
            r_o_sen <= 1'b0;
            {r_o_cx, r_o_cy, r_o_x1, r_o_y1, r_o_x2, r_o_y2} <= '0;
        end else if (frame_start) begin
            r_o_cen <= (r_state != ST_IDLE);
            r_o_sen <= (r_state == ST_ANC) || (r_state == ST_LOCK);
            {r_o_cx, r_o_cy, r_o_x1, r_o_y1, r_o_x2, r_o_y2} <=
                {r_cx, r_cy, r_x1, r_y1, r_x2, r_y2};
        end
    end

    assign cursor_enable    = r_o_cen;
    assign cursor_x         = r_o_cx;
    assign cursor_y         = r_o_cy;
    assign selection_enable = r_o_sen;
    assign sel_x1           = r_o_x1;
    assign sel_y1           = r_o_y1;
    assign sel_x2           = r_o_x2;
    assign sel_y2           = r_o_y2;
    assign sel_done         = r_sel_done;
    assign state_o          = r_state;

endmodule

// File: tb/tb_cursor_selection_ctrl.sv
// Directed bench for cursor_selection_ctrl (default build, no acceleration).
module tb_cursor_selection_ctrl;

    logic       clk_vga = 1'b0;
    logic       reset = 1'b1;
    logic       frame_start = 1'b0, ctrl_enable = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       btn_select = 1'b0, btn_cancel = 1'b0;
    logic [9:0] img_w = 10'd160, img_h = 10'd120;
    logic       cursor_enable, selection_enable, sel_done;
    logic [9:0] cursor_x, cursor_y, sel_x1, sel_y1, sel_x2, sel_y2;
    logic [1:0] state_o;

    int checks = 0;
    int errors = 0;

    cursor_selection_ctrl dut (
        .clk_vga(clk_vga), .reset(reset), .frame_start(frame_start),
        .ctrl_enable(ctrl_enable),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_select(btn_select), .btn_cancel(btn_cancel),
        .img_w(img_w), .img_h(img_h),
        .cursor_enable(cursor_enable), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .selection_enable(selection_enable),
        .sel_x1(sel_x1), .sel_y1(sel_y1), .sel_x2(sel_x2), .sel_y2(sel_y2),
        .sel_done(sel_done), .state_o(state_o)
    );

    always #5 clk_vga = ~clk_vga;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_vga);
    endtask

    task automatic frame();
        @(negedge clk_vga) frame_start = 1'b1;
        @(negedge clk_vga) frame_start = 1'b0;
    endtask

    // 0 up, 1 down, 2 left, 3 right, 4 select, 5 cancel
    task automatic set_btn(input int d, input logic v);
        case (d)
            0: btn_up = v;
            1: btn_down = v;
            2: btn_left = v;
            3: btn_right = v;
            4: btn_select = v;
            default: btn_cancel = v;
        endcase
    endtask

    task automatic press(input int d);
        @(negedge clk_vga) set_btn(d, 1'b1);
        @(negedge clk_vga) set_btn(d, 1'b0);
        @(negedge clk_vga);
    endtask

    initial begin
        // Reset state
        tick(2);
        chk("rst_state", state_o, 0);
        chk("rst_cen", cursor_enable, 0);
        chk("rst_sel_done", sel_done, 0);
        reset = 1'b0;
        tick(2);
        frame();
        chk("idle_cen", cursor_enable, 0);

        // Enable: centre of 160x120, visible only after frame_start
        ctrl_enable = 1'b1;
        tick(2);
        chk("en_state", state_o, 1);
        chk("en_cen_preframe", cursor_enable, 0);
        frame();
        chk("en_cen", cursor_enable, 1);
        chk("en_cx", cursor_x, 80);
        chk("en_cy", cursor_y, 60);
        chk("en_sen", selection_enable, 0);

        // Hold down for 30 frames: press step + repeats at 20, 24, 28
        btn_down = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            frame();
            if (k == 20) begin
                chk("rep_y_f20", cursor_y, 61);
                tick(3);
                chk("rep_y_hold", cursor_y, 61);
            end
            if (k == 21) chk("rep_y_f21", cursor_y, 62);
        end
        chk("rep_y_f30", cursor_y, 64);
        btn_down = 1'b0;
        tick(2);

        // Right clamp at x=159
        ctrl_enable = 1'b0;
        tick(2);
        chk("dis_state", state_o, 0);
        frame();
        chk("dis_cen", cursor_enable, 0);
        chk("dis_cx", cursor_x, 0);
        img_w = 10'd318;
        ctrl_enable = 1'b1;
        tick(2);
        img_w = 10'd160;
        tick(2);
        press(3);
        tick(2);
        frame();
        chk("clamp_right", cursor_x, 159);
        chk("clamp_right_y", cursor_y, 60);

        // Left clamp at x=0, shrink re-clamp on both axes
        img_w = 10'd2;
        tick(2);
        frame();
        chk("shrink_x", cursor_x, 1);
        press(2);
        press(2);
        img_h = 10'd0;
        tick(2);
        frame();
        chk("clamp_left", cursor_x, 0);
        chk("zero_h_y", cursor_y, 0);
        img_w = 10'd160;
        img_h = 10'd120;
        tick(2);

        // Navigate to (10,10), anchor, move (+5,+3), lock
        for (int i = 0; i < 10; i++) press(3);
        for (int i = 0; i < 10; i++) press(1);
        tick(2);
        frame();
        chk("nav_x", cursor_x, 10);
        chk("nav_y", cursor_y, 10);
        press(4);
        chk("anc_state", state_o, 2);
        for (int i = 0; i < 5; i++) press(3);
        for (int i = 0; i < 3; i++) press(1);
        @(negedge clk_vga) btn_select = 1'b1;
        @(negedge clk_vga);
        chk("lock_state", state_o, 3);
        chk("lock_done_hi", sel_done, 1);
        btn_select = 1'b0;
        @(negedge clk_vga);
        chk("lock_done_lo", sel_done, 0);
        frame();
        chk("lock_sen", selection_enable, 1);
        chk("lock_x1", sel_x1, 10);
        chk("lock_y1", sel_y1, 10);
        chk("lock_x2", sel_x2, 15);
        chk("lock_y2", sel_y2, 13);
        press(3);
        tick(2);
        frame();
        chk("frozen_cx", cursor_x, 15);
        chk("frozen_x2", sel_x2, 15);

        // Cancel from LOCKED
        press(5);
        chk("cancel_state", state_o, 1);
        frame();
        chk("cancel_sen", selection_enable, 0);
        chk("cancel_x1", sel_x1, 0);
        chk("cancel_cx", cursor_x, 15);

        // Opposing left+right: no motion
        @(negedge clk_vga) begin btn_left = 1'b1; btn_right = 1'b1; end
        tick(3);
        btn_left = 1'b0;
        btn_right = 1'b0;
        tick(2);
        frame();
        chk("oppose_cx", cursor_x, 15);

        // Select and cancel together in ANCHORED: cancel wins
        press(4);
        chk("anc2_state", state_o, 2);
        @(negedge clk_vga) begin btn_select = 1'b1; btn_cancel = 1'b1; end
        @(negedge clk_vga);
        chk("both_state", state_o, 1);
        chk("both_done", sel_done, 0);
        btn_select = 1'b0;
        btn_cancel = 1'b0;
        @(negedge clk_vga);
        chk("both_done2", sel_done, 0);
        frame();
        chk("both_sen", selection_enable, 0);

        // Reset mid-frame while LOCKED
        press(4);
        press(4);
        chk("relock_state", state_o, 3);
        frame();
        chk("relock_sen", selection_enable, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_cen", cursor_enable, 0);
        chk("arst_cx", cursor_x, 0);
        chk("arst_sen", selection_enable, 0);
        chk("arst_x2", sel_x2, 0);
        chk("arst_state", state_o, 0);
        tick(2);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cursor_selection_ctrl.md
Name: cursor_selection_ctrl

Overview:
- Owns the cursor and selection configuration consumed by the VGA cursor overlay: cursor enable and position, selection enable and both corners.
- Turns debounced direction, select and cancel buttons into clamped cursor motion with auto-repeat, and runs a select/anchor/lock state machine.
- Publishes overlay-facing registers only at frame start, so the overlay never tears mid-frame.

Parameters:
- STEP, 1, cursor pixels moved per step (image coordinates).
- REPEAT_DELAY, 20, frame_start pulses a direction must be held before auto-repeat begins.
- REPEAT_PERIOD, 4, frame_start pulses between auto-repeat steps.

Ports:
- clk_vga  in  1  pixel clock (only clock).
- reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- ctrl_enable  in  1  level; 0 forces IDLE.
- btn_up, btn_down, btn_left, btn_right  in  1 each  debounced, synchronous levels, active-high.
- btn_select, btn_cancel  in  1 each  debounced levels, active-high.
- img_w, img_h  in  10 each  logical image size; the cursor range is 0..size-1.
- cursor_enable  out  1  to overlay.
- cursor_x, cursor_y  out  10 each  to overlay.
- selection_enable  out  1  to overlay.
- sel_x1, sel_y1, sel_x2, sel_y2  out  10 each  raw corners (overlay normalises).
- sel_done  out  1  one-cycle pulse when a selection locks.
- state_o  out  2  current FSM state, for debug/CPU readback.

Behaviour:
- Reset: every output 0, FSM IDLE, all counters 0, working registers 0. Reset may assert mid-operation and takes effect immediately.
- FSM states: IDLE=0, NAVIGATE=1, ANCHORED=2, LOCKED=3.
- IDLE:
  - Cursor and selection are disabled.
  - On ctrl_enable=1, go to NAVIGATE and set working cursor = (img_w>>1, img_h>>1).
- NAVIGATE:
  - Direction steps move the cursor.
  - Rising edge of select: go to ANCHORED; corner1 = corner2 = cursor.
- ANCHORED:
  - Steps move the cursor; corner2 tracks the cursor in the same cycle as each move.
  - Rising edge of select: go to LOCKED; pulse sel_done one cycle later.
  - Rising edge of cancel: go to NAVIGATE; selection disabled; corners zeroed.
- LOCKED:
  - Direction inputs are ignored; cursor and corners are frozen.
  - Rising edge of cancel: go to NAVIGATE; selection cleared.
- ctrl_enable=0 in any state: go to IDLE next cycle; working registers zeroed.
- select and cancel edges in the same cycle: cancel wins. In NAVIGATE the select edge is then dropped.
- Step generation, per direction:
  - Rising edge gives one step applied next cycle.
  - While held, count frame_start pulses. At count REPEAT_DELAY give a step, then one step every further REPEAT_PERIOD pulses.
  - Release clears the counter. Counters saturate and do not wrap.
- Opposing directions held together (left+right or up+down): no motion on that axis. Each direction's counter keeps running.
- Arithmetic and clamping:
  - Use 11-bit intermediates.
  - x_new = min(x+step, img_w-1) and max(x-step, 0). Same for y.
  - img_w or img_h of 0 clamps that axis to 0.
  - If img_w or img_h shrinks, the working cursor and corners are re-clamped on the next cycle.
- Output shadowing:
  - Overlay outputs (cursor_*, selection_enable, sel_*) load from the working registers on the cycle after frame_start, and hold otherwise.
  - Latency from a button edge to a visible output is up to 1 frame + 2 cycles.
  - sel_done and state_o are not shadowed.

Optional Feature:
- Macro: CURSOR_SELECTION_CTRL_ACCEL_EN.
- Defined: after 8 consecutive auto-repeat steps on one held direction, the step size becomes 4*STEP until that direction is released. The clamp still applies.
- Undefined: the step size is always STEP and there is no extra counter logic.

Decomposition:
- Package cursor_ctrl_pkg holds:
  - FSM state encodings (IDLE/NAVIGATE/ANCHORED/LOCKED).
  - Coordinate width constant COORD_W=10.
  - Accel threshold 8 and multiplier 4.
- Sub-module cursor_key_repeat:
  - Inputs: clk_vga, reset, btn, frame_start.
  - Output: one-cycle step pulse.
  - Contains edge detect plus the delay/period counter (and the accel counter when the macro is defined).
  - Instantiated four times.

Test Plan:
- Reset, then ctrl_enable=1 with img_w=160, img_h=120, then one frame_start → cursor_enable=1, cursor=(80,60), selection_enable=0, state_o=1.
- Cursor at x=159, press right for 1 cycle, then frame_start → cursor_x stays 159. Cursor at x=0, press left → stays 0.
- Hold btn_down for 30 frame_start pulses from y=60 (accel macro off) → y=64 (1 press step plus repeats at pulses 20, 24, 28); outputs change only on the cycle after frame_start.
- Select at (10,10), move right 5 and down 3, select again → ANCHORED then LOCKED; sel=(10,10,15,13); sel_done high exactly one cycle; a later btn_right leaves all values unchanged.
- In ANCHORED, assert select and cancel rising in the same cycle → state NAVIGATE, selection_enable=0 after the next frame_start, sel_done stays 0.
- In LOCKED, assert reset mid-frame → all outputs 0 immediately, state_o=0.
